// File: rtl/cam_pixel_packer.sv
// Camera byte-stream to RGB565 packer feeding an async FIFO write port (w_clk domain).
// Optional 2x2 downscale enabled by defining CAM_PACK_DECIMATE_EN (adds the decimate input).
//
// state   | meaning
// IDLE    | not capturing; arm clears sticky status and starts a capture
// WAIT_VS | armed, waiting for VSYNC fall (frame start)
// CAPTURE | packing bytes of the current frame until VSYNC rise (frame end)
module cam_pixel_packer #(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480,
  parameter int CNT_W       = 10
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  input  logic             arm,
  input  logic             continuous,
`ifdef CAM_PACK_DECIMATE_EN
  input  logic             decimate,
`endif
  input  logic             w_full,
  input  logic             w_almost_full,
  output logic [15:0]      w_data,
  output logic             w_inc,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] lines_dropped
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LINE_PIX_C    = CNT_W'(LINE_PIXELS);
  localparam logic [CNT_W-1:0] FRAME_LINES_C = CNT_W'(FRAME_LINES);

  state_t           state, state_nxt;
  logic             vsync_d, href_d;
  logic             phase, skip_line, dec_line_off;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] pix_cnt, line_cnt;

  logic frame_start, frame_end, line_start, href_fall;
  logic arm_clear, frame_clear, cap_active, end_frame;
  logic dec_on, dec_line_drop, pix_write_ok;

`ifdef CAM_PACK_DECIMATE_EN
  assign dec_on = decimate;
`else
  assign dec_on = 1'b0;
`endif

  assign frame_start = !cam_vsync && vsync_d;
  assign frame_end   = cam_vsync && !vsync_d;
  assign line_start  = cam_href && !href_d;
  assign href_fall   = !cam_href && href_d;

  // line_cnt still holds the zero-based index of the line that is starting
  assign dec_line_drop = dec_on && line_cnt[0];
  assign pix_write_ok  = !dec_line_off && !(dec_on && pix_cnt[0]);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    arm_clear   = 1'b0;
    frame_clear = 1'b0;
    cap_active  = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = WAIT_VS;
          arm_clear = 1'b1;
        end
      end
      WAIT_VS: begin
        if (frame_start) begin
          state_nxt   = CAPTURE;
          frame_clear = 1'b1;
        end
      end
      CAPTURE: begin
        if (frame_end) begin
          end_frame = 1'b1;
          state_nxt = continuous ? WAIT_VS : IDLE;
        end else begin
          cap_active = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      vsync_d       <= 1'b0;
      href_d        <= 1'b0;
      phase         <= 1'b0;
      skip_line     <= 1'b0;
      dec_line_off  <= 1'b0;
      hi_byte       <= '0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      w_data        <= '0;
      w_inc         <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
      lines_dropped <= '0;
    end else begin
      vsync_d    <= cam_vsync;
      href_d     <= cam_href;
      w_inc      <= 1'b0;
      frame_done <= end_frame;
      busy       <= (state_nxt != IDLE);

      if (arm_clear) begin
        frame_err     <= 1'b0;
        overflow      <= 1'b0;
        lines_dropped <= '0;
      end

      if (frame_clear) begin
        line_cnt     <= '0;
        pix_cnt      <= '0;
        phase        <= 1'b0;
        skip_line    <= 1'b0;
        dec_line_off <= 1'b0;
      end

      // frame end also cuts off any line still in flight, dropping its partial byte
      if (end_frame) begin
        phase <= 1'b0;
        if (line_cnt != FRAME_LINES_C) frame_err <= 1'b1;
      end

      if (cap_active) begin
        if (line_start) begin
          pix_cnt      <= '0;
          dec_line_off <= dec_line_drop;
          if (line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_ONE;
          if (w_almost_full && !dec_line_drop) begin
            skip_line <= 1'b1;
            phase     <= 1'b0;
            if (lines_dropped != CNT_MAX) lines_dropped <= lines_dropped + CNT_ONE;
          end else begin
            skip_line <= 1'b0;
            hi_byte   <= cam_data;
            phase     <= 1'b1;
          end
        end else if (cam_href && !skip_line) begin
          if (!phase) begin
            hi_byte <= cam_data;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_ONE;
            if (pix_write_ok) begin
              if (w_full) begin
                overflow  <= 1'b1;
                frame_err <= 1'b1;
              end else begin
                w_inc  <= 1'b1;
                w_data <= {hi_byte, cam_data};
              end
            end
          end
        end else if (href_fall) begin
          phase <= 1'b0;
          // a dangling high byte means the line had an odd byte count
          if (!skip_line && (pix_cnt != LINE_PIX_C || phase)) frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer with a 4x4-pixel frame geometry.
// Decimation case is compiled only when CAM_PACK_DECIMATE_EN is defined.
module tb_cam_pixel_packer;

  localparam int CNT_W = 4;

  logic             w_clk, w_rst;
  logic             cam_vsync, cam_href;
  logic [7:0]       cam_data;
  logic             arm, continuous;
  logic             w_full, w_almost_full;
  logic [15:0]      w_data;
  logic             w_inc, busy, frame_done, frame_err, overflow;
  logic [CNT_W-1:0] lines_dropped;
`ifdef CAM_PACK_DECIMATE_EN
  logic             decimate;
`endif

  cam_pixel_packer #(.LINE_PIXELS(4), .FRAME_LINES(4), .CNT_W(CNT_W)) dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .arm           (arm),
    .continuous    (continuous),
`ifdef CAM_PACK_DECIMATE_EN
    .decimate      (decimate),
`endif
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_data        (w_data),
    .w_inc         (w_inc),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .overflow      (overflow),
    .lines_dropped (lines_dropped)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          n_b2b = 0;
  logic        prev_inc = 1'b0;
  logic [15:0] words[$];

  always @(negedge w_clk) begin
    if (w_inc) begin
      n_wr++;
      words.push_back(w_data);
      if (prev_inc) n_b2b++;
    end
    if (frame_done) n_done++;
    prev_inc = w_inc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge w_clk);
      #1;
    end
  endtask

  function automatic logic [7:0] pix_byte(input int l, input int k);
    logic [3:0] lb, kb;
    if (l == 0 && k == 0) return 8'hA1;
    if (l == 0 && k == 1) return 8'hB2;
    lb = 4'(l);
    kb = 4'(k);
    return {lb, kb};
  endfunction

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_line(input int l, input int nbytes, input int full_byte, input logic af);
    for (int k = 0; k < nbytes; k++) begin
      cam_href      = 1'b1;
      cam_data      = pix_byte(l, k);
      w_full        = (k == full_byte);
      w_almost_full = af && (k == 0);
      tick();
    end
    cam_href      = 1'b0;
    w_full        = 1'b0;
    w_almost_full = 1'b0;
    cam_data      = 8'h00;
    tick(2);
  endtask

  // long_line gets 9 bytes; full_line/full_byte marks the byte seeing w_full; af_line starts under almost-full
  task automatic send_frame(input int long_line, input int full_line, input int full_byte, input int af_line);
    cam_vsync = 1'b1;
    tick(2);
    cam_vsync = 1'b0;
    tick(2);
    for (int l = 0; l < 4; l++)
      send_line(l, (l == long_line) ? 9 : 8, (l == full_line) ? full_byte : -1, l == af_line);
    cam_vsync = 1'b1;
    tick(4);
  endtask

  int wr_base, wd_base, done_base;

  task automatic mark();
    wr_base   = n_wr;
    wd_base   = words.size();
    done_base = n_done;
  endtask

  initial begin
    w_rst = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    arm = 1'b0; continuous = 1'b0; w_full = 1'b0; w_almost_full = 1'b0;
`ifdef CAM_PACK_DECIMATE_EN
    decimate = 1'b0;
`endif
    tick(3);
    check_eq("rst_w_inc", w_inc, 0);
    check_eq("rst_w_data", w_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {frame_done, frame_err, overflow}, 0);
    check_eq("rst_dropped", lines_dropped, 0);
    w_rst = 1'b0;
    tick(2);

    // single frame, clean
    mark();
    pulse_arm();
    check_eq("busy_after_arm", busy, 1);
    send_frame(-1, -1, -1, -1);
    check_eq("t1_writes", n_wr - wr_base, 16);
    check_eq("t1_first_word", words[wd_base], 16'hA1B2);
    check_eq("t1_last_word", words[wd_base + 15], 16'h3637);
    check_eq("t1_done", n_done - done_base, 1);
    check_eq("t1_err", frame_err, 0);
    check_eq("t1_idle", busy, 0);

    // w_full on the completing byte of pixel 3 of line 1
    mark();
    pulse_arm();
    send_frame(-1, 1, 7, -1);
    check_eq("t2_writes", n_wr - wr_base, 15);
    check_eq("t2_after_gap", words[wd_base + 7], 16'h2021);
    check_eq("t2_overflow", overflow, 1);
    check_eq("t2_err", frame_err, 1);
    pulse_arm();
    check_eq("t2_ovf_clear", overflow, 0);
    check_eq("t2_err_clear", frame_err, 0);

    // almost-full at start of line 2 (already armed above)
    mark();
    send_frame(-1, -1, -1, 2);
    check_eq("t3_writes", n_wr - wr_base, 12);
    check_eq("t3_dropped", lines_dropped, 1);
    check_eq("t3_err", frame_err, 0);
    check_eq("t3_line3_word", words[wd_base + 8], 16'h3031);

    // 9-byte line 1
    mark();
    pulse_arm();
    check_eq("t4_dropped_clear", lines_dropped, 0);
    send_frame(1, -1, -1, -1);
    check_eq("t4_writes", n_wr - wr_base, 16);
    check_eq("t4_line2_word", words[wd_base + 8], 16'h2021);
    check_eq("t4_err", frame_err, 1);

    // continuous over 3 frames
    mark();
    continuous = 1'b1;
    pulse_arm();
    for (int f = 0; f < 3; f++) send_frame(-1, -1, -1, -1);
    check_eq("t5_done", n_done - done_base, 3);
    check_eq("t5_writes", n_wr - wr_base, 48);
    check_eq("t5_err", frame_err, 0);
    check_eq("t5_busy", busy, 1);

    // reset in the middle of the next frame
    cam_vsync = 1'b0;
    tick(2);
    send_line(0, 8, -1, 1'b0);
    cam_href = 1'b1; cam_data = 8'h55;
    tick();
    w_rst = 1'b1;
    tick();
    check_eq("rst_mid_w_data", w_data, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_flags", {w_inc, frame_done, frame_err, overflow}, 0);
    w_rst = 1'b0;
    cam_href = 1'b0;
    tick(2);
    mark();
    for (int l = 1; l < 4; l++) send_line(l, 8, -1, 1'b0);
    cam_vsync = 1'b1;
    tick(3);
    send_frame(-1, -1, -1, -1);
    check_eq("rst_no_writes", n_wr - wr_base, 0);
    continuous = 1'b0;
    pulse_arm();
    send_frame(-1, -1, -1, -1);
    check_eq("rst_rearm_writes", n_wr - wr_base, 16);
    check_eq("rst_rearm_err", frame_err, 0);

`ifdef CAM_PACK_DECIMATE_EN
    mark();
    decimate = 1'b1;
    pulse_arm();
    send_frame(-1, -1, -1, -1);
    check_eq("dec_writes", n_wr - wr_base, 4);
    check_eq("dec_p00", words[wd_base], 16'hA1B2);
    check_eq("dec_p02", words[wd_base + 1], 16'h0405);
    check_eq("dec_p20", words[wd_base + 2], 16'h2021);
    check_eq("dec_p22", words[wd_base + 3], 16'h2425);
    check_eq("dec_err", frame_err, 0);
    decimate = 1'b0;
`endif

    check_eq("no_back_to_back", n_b2b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
